// File: rtl/engine_rr_scheduler_if.sv
// Requester/engine signal bundle around engine_rr_scheduler.
// slave = scheduler view, master = surrounding datapath view.
interface engine_rr_scheduler_if #(
    parameter int V_W = 16,
    parameter int U_W = 2,
    parameter int D_W = 21
);
    logic           req0;
    logic           req1;
    logic [V_W-1:0] v0;
    logic [V_W-1:0] v1;
    logic [U_W-1:0] u0;
    logic [U_W-1:0] u1;
    logic           gnt0;
    logic           gnt1;
    logic           done0;
    logic           done1;
    logic           res_valid;
    logic           res_id;
    logic [D_W-1:0] res_data;
    logic           err;
    logic           timeout_flag;
    logic           eng_start;
    logic [V_W-1:0] eng_v;
    logic [U_W-1:0] eng_u;
    logic           eng_done;
    logic           eng_wr_req;
    logic [D_W-1:0] eng_wr_data;

    modport slave (
        input  req0, req1, v0, v1, u0, u1,
        input  eng_done, eng_wr_req, eng_wr_data,
        output gnt0, gnt1, done0, done1,
        output res_valid, res_id, res_data,
        output err, timeout_flag,
        output eng_start, eng_v, eng_u
    );

    modport master (
        output req0, req1, v0, v1, u0, u1,
        output eng_done, eng_wr_req, eng_wr_data,
        input  gnt0, gnt1, done0, done1,
        input  res_valid, res_id, res_data,
        input  err, timeout_flag,
        input  eng_start, eng_v, eng_u
    );
endinterface

// File: rtl/engine_rr_scheduler.sv
// Round-robin owner of one start/done engine shared by two requesters.
// Define WATCHDOG_EN to bound WAIT by TIMEOUT_CYCLES (drives err/timeout_flag).
module engine_rr_scheduler #(
    parameter int V_W            = 16,
    parameter int U_W            = 2,
    parameter int D_W            = 21,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                  clock,
    input logic                  reset,
    engine_rr_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic           id_q, id_d;
    logic [V_W-1:0] v_q, v_d;
    logic [U_W-1:0] u_q, u_d;
    logic           gnt0_q, gnt0_d;
    logic           gnt1_q, gnt1_d;
    logic           start_q, start_d;
    logic           done0_q, done0_d;
    logic           done1_q, done1_d;
    logic           rv_q, rv_d;
    logic [D_W-1:0] rd_q, rd_d;
    logic           any_req;
    logic           take;
    logic           win;
    logic           fin;
    logic           tmo;

    assign any_req = bus.req0 | bus.req1;
    assign take    = (state_q == S_IDLE) & any_req;
    // On a tie prio_q names the requester that was not served last.
    assign win     = (bus.req0 & bus.req1) ? prio_q : bus.req1;
    assign fin     = (state_q == S_WAIT) & (bus.eng_done | tmo);

`ifdef WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          tflag_q, tflag_d;

    // A real eng_done on the terminal-count cycle beats the timeout.
    assign tmo     = (state_q == S_WAIT) & ~bus.eng_done & (cnt_q == CNT_LAST);
    assign cnt_d   = (state_q == S_WAIT) ? cnt_q + CW'(1) : '0;
    assign err_d   = tmo;
    assign tflag_d = tflag_q | tmo;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            tflag_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            tflag_q <= tflag_d;
        end
    end

    assign bus.err          = err_q;
    assign bus.timeout_flag = tflag_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign tmo                = 1'b0;
    assign bus.err            = 1'b0;
    assign bus.timeout_flag   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (any_req) state_d = S_GRANT;
            S_GRANT: state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (fin) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        id_d = id_q;
        v_d  = v_q;
        u_d  = u_q;
        if (take) begin
            id_d = win;
            v_d  = win ? bus.v1 : bus.v0;
            u_d  = win ? bus.u1 : bus.u0;
        end
        gnt0_d  = (state_q == S_GRANT) & ~id_q;
        gnt1_d  = (state_q == S_GRANT) & id_q;
        start_d = (state_q == S_ISSUE);
        rv_d    = (state_q == S_WAIT) & bus.eng_wr_req;
        rd_d    = rv_d ? bus.eng_wr_data : rd_q;
        done0_d = fin & ~id_q;
        done1_d = fin & id_q;
        prio_d  = fin ? ~id_q : prio_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            v_q     <= '0;
            u_q     <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            start_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
        end else begin
            prio_q  <= prio_d;
            id_q    <= id_d;
            v_q     <= v_d;
            u_q     <= u_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            start_q <= start_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.eng_start = start_q;
    assign bus.eng_v     = v_q;
    assign bus.eng_u     = u_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.res_valid = rv_q;
    assign bus.res_id    = id_q;
    assign bus.res_data  = rd_q;

endmodule

// File: tb/tb_engine_rr_scheduler.sv
// Randomized self-checking bench for engine_rr_scheduler.
// Build with WATCHDOG_EN (RTL and bench) to also cover the timeout path.
module tb_engine_rr_scheduler;

    localparam int V_W = 16;
    localparam int U_W = 2;
    localparam int D_W = 21;
`ifdef WATCHDOG_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif
    localparam int OW = 8 + D_W;
    localparam int AW = OW + 1 + V_W + U_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    engine_rr_scheduler_if #(.V_W(V_W), .U_W(U_W), .D_W(D_W)) bus ();

    engine_rr_scheduler #(
        .V_W(V_W),
        .U_W(U_W),
        .D_W(D_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit             served_any;
    int             last_served;
    bit             tflag_m;
    logic [D_W-1:0] exp_data;
    logic [V_W-1:0] vq[2];
    logic [U_W-1:0] uq[2];
    bit             pend[2];
    logic [D_W-1:0] wq[$];

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) return served_any ? 1 - last_served : 0;
        return r1 ? 1 : 0;
    endfunction

    function automatic logic [OW-1:0] obs();
        return {bus.gnt0, bus.gnt1, bus.eng_start, bus.res_valid,
                bus.done0, bus.done1, bus.err, bus.timeout_flag,
                bus.res_data};
    endfunction

    function automatic logic [OW-1:0] quiet();
        return {7'b0, tflag_m, exp_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.v0 = '0;
        bus.v1 = '0;
        bus.u0 = '0;
        bus.u1 = '0;
        bus.eng_done = 1'b0;
        bus.eng_wr_req = 1'b0;
        bus.eng_wr_data = '0;
    endtask

    task automatic do_reset(input int n);
        clear_inputs();
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        served_any = 1'b0;
        last_served = 0;
        tflag_m = 1'b0;
        exp_data = '0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
    endtask

    task automatic raise(input int i, input logic [V_W-1:0] v,
                         input logic [U_W-1:0] u);
        vq[i] = v;
        uq[i] = u;
        pend[i] = 1'b1;
        if (i == 0) begin
            bus.req0 = 1'b1;
            bus.v0 = v;
            bus.u0 = u;
        end else begin
            bus.req1 = 1'b1;
            bus.v1 = v;
            bus.u1 = u;
        end
    endtask

    // Req just driven while IDLE: gnt one cycle after sampling, then start.
    task automatic grant_phase(input int id, input bit noise);
        logic [OW-1:0] o;
        logic [OW-1:0] e;
        if (noise) begin
            bus.eng_done = 1'b1;
            bus.eng_wr_req = 1'b1;
            bus.eng_wr_data = D_W'($urandom);
        end
        tick();
        o = obs();
        e = quiet();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL pre_grant id=%0d: got %h expected %h", id, o, e);
        end
        tick();
        o = obs();
        e = {id == 0, id == 1, 5'b0, tflag_m, exp_data};
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL grant id=%0d: got %h expected %h", id, o, e);
        end
        if (id == 0) bus.req0 = 1'b0;
        else bus.req1 = 1'b0;
        pend[id] = 1'b0;
        tick();
        o = obs();
        e = {3'b001, 4'b0, tflag_m, exp_data};
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL issue id=%0d: got %h expected %h", id, o, e);
        end
        checks++;
        if ({bus.eng_v, bus.eng_u} !== {vq[id], uq[id]}) begin
            errors++;
            $display("FAIL operands id=%0d: got %h/%h expected %h/%h",
                     id, bus.eng_v, bus.eng_u, vq[id], uq[id]);
        end
        bus.eng_done = 1'b0;
        bus.eng_wr_req = 1'b0;
    endtask

    // mode 0: normal, 1: engine hangs, 2: eng_done exactly at terminal count
    task automatic engine_job(input int id, input bit merge, input int mode);
        bit             ws[$];
        bit             ds[$];
        logic [D_W-1:0] dd[$];
        logic [OW-1:0]  o;
        logic [OW-1:0]  e;
        bit             fin;
        bit             tmo;
        foreach (wq[k]) begin
            repeat ($urandom_range(0, 2)) begin
                ws.push_back(1'b0);
                ds.push_back(1'b0);
                dd.push_back(D_W'($urandom));
            end
            ws.push_back(1'b1);
            ds.push_back(1'b0);
            dd.push_back(wq[k]);
        end
        if (mode != 0) begin
            while (ws.size() < TMO) begin
                ws.push_back(1'b0);
                ds.push_back(1'b0);
                dd.push_back(D_W'($urandom));
            end
            if (mode == 2) ds[TMO-1] = 1'b1;
        end else if (merge && ws.size() > 0) begin
            ds[ds.size()-1] = 1'b1;
        end else begin
            repeat ($urandom_range(0, 2)) begin
                ws.push_back(1'b0);
                ds.push_back(1'b0);
                dd.push_back(D_W'($urandom));
            end
            ws.push_back(1'b0);
            ds.push_back(1'b1);
            dd.push_back(D_W'($urandom));
        end
        for (int i = 0; i < ws.size(); i++) begin
            bus.eng_wr_req = ws[i];
            bus.eng_done = ds[i];
            bus.eng_wr_data = dd[i];
            tick();
            tmo = (mode == 1) && (i + 1 == TMO);
            fin = ds[i] || tmo;
            if (ws[i]) exp_data = dd[i];
            if (tmo) tflag_m = 1'b1;
            o = obs();
            e = {3'b000, ws[i], fin && id == 0, fin && id == 1, tmo,
                 tflag_m, exp_data};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wait id=%0d t=%0d: got %h expected %h",
                         id, i + 1, o, e);
            end
            if (ws[i] || fin) begin
                checks++;
                if (bus.res_id !== 1'(id)) begin
                    errors++;
                    $display("FAIL res_id t=%0d: got %0d expected %0d",
                             i + 1, bus.res_id, id);
                end
            end
            checks++;
            if ({bus.eng_v, bus.eng_u} !== {vq[id], uq[id]}) begin
                errors++;
                $display("FAIL operand_hold id=%0d: got %h/%h expected %h/%h",
                         id, bus.eng_v, bus.eng_u, vq[id], uq[id]);
            end
        end
        bus.eng_wr_req = 1'b0;
        bus.eng_done = 1'b0;
        served_any = 1'b1;
        last_served = id;
    endtask

    task automatic rand_words(input int lo, input int hi);
        wq.delete();
        repeat ($urandom_range(lo, hi)) wq.push_back(D_W'($urandom));
    endtask

    task automatic test_reset();
        logic [AW-1:0] a;
        do_reset(10);
        for (int c = 0; c < 50; c++) begin
            tick();
            a = {obs(), bus.res_id, bus.eng_v, bus.eng_u};
            checks++;
            if (a !== '0) begin
                errors++;
                $display("FAIL reset_idle c=%0d: got %h expected 0", c, a);
            end
        end
    endtask

    task automatic test_single();
        raise(0, 16'h1F00, 2'd3);
        grant_phase(0, 1'b0);
        wq.delete();
        wq.push_back(21'h000123);
        wq.push_back(21'h1ABCDE);
        engine_job(0, 1'b0, 0);
    endtask

    task automatic test_alternate();
        int id;
        do_reset(2);
        raise(0, V_W'($urandom), U_W'($urandom));
        raise(1, V_W'($urandom), U_W'($urandom));
        for (int j = 0; j < 6; j++) begin
            id = pick(pend[0], pend[1]);
            grant_phase(id, 1'b0);
            rand_words(1, 2);
            engine_job(id, 1'b0, 0);
            raise(id, V_W'($urandom), U_W'($urandom));
        end
    endtask

    task automatic test_reset_mid_job();
        logic [AW-1:0] a;
        logic [OW-1:0] o;
        logic [OW-1:0] e;
        do_reset(2);
        raise(0, V_W'($urandom), U_W'($urandom));
        grant_phase(0, 1'b0);
        rand_words(1, 1);
        engine_job(0, 1'b0, 0);
        raise(1, V_W'($urandom), U_W'($urandom));
        grant_phase(1, 1'b0);
        bus.eng_wr_req = 1'b1;
        bus.eng_wr_data = D_W'($urandom);
        exp_data = bus.eng_wr_data;
        tick();
        o = obs();
        e = {3'b000, 1'b1, 3'b000, tflag_m, exp_data};
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL pre_abort: got %h expected %h", o, e);
        end
        bus.eng_wr_req = 1'b0;
        bus.eng_done = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            a = {obs(), bus.res_id, bus.eng_v, bus.eng_u};
            checks++;
            if (a !== '0) begin
                errors++;
                $display("FAIL abort c=%0d: got %h expected 0", c, a);
            end
            tick();
        end
        bus.eng_done = 1'b0;
        served_any = 1'b0;
        last_served = 0;
        tflag_m = 1'b0;
        exp_data = '0;
        raise(0, V_W'($urandom), U_W'($urandom));
        raise(1, V_W'($urandom), U_W'($urandom));
        for (int j = 0; j < 2; j++) begin
            int id;
            id = pick(pend[0], pend[1]);
            grant_phase(id, 1'b0);
            rand_words(0, 2);
            engine_job(id, 1'b0, 0);
        end
    endtask

    task automatic test_merge();
        int id;
        for (int j = 0; j < 4; j++) begin
            id = $urandom_range(0, 1);
            raise(id, V_W'($urandom), U_W'($urandom));
            grant_phase(id, 1'b0);
            rand_words(1, 3);
            engine_job(id, 1'b1, 0);
        end
    endtask

    task automatic test_ignored();
        logic [OW-1:0] o;
        logic [OW-1:0] e;
        do_reset(2);
        for (int c = 0; c < 4; c++) begin
            bus.eng_done = 1'b1;
            bus.eng_wr_req = 1'b1;
            bus.eng_wr_data = D_W'($urandom);
            tick();
            o = obs();
            e = quiet();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL idle_engine_noise c=%0d: got %h expected %h", c, o, e);
            end
        end
        bus.eng_done = 1'b0;
        bus.eng_wr_req = 1'b0;
        raise(1, V_W'($urandom), U_W'($urandom));
        grant_phase(1, 1'b1);
        rand_words(1, 1);
        engine_job(1, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [OW-1:0] o;
        logic [OW-1:0] e;
        do_reset(2);
        for (int j = 0; j < 40; j++) begin
            int  r;
            int  id;
            bit  mg;
            bit  nz;
            if (!pend[0] && !pend[1]) begin
                repeat ($urandom_range(0, 3)) begin
                    tick();
                    o = obs();
                    e = quiet();
                    checks++;
                    if (o !== e) begin
                        errors++;
                        $display("FAIL idle_gap j=%0d: got %h expected %h", j, o, e);
                    end
                end
            end
            r = $urandom_range(1, 3);
            if (r[0] && !pend[0]) raise(0, V_W'($urandom), U_W'($urandom));
            if (r[1] && !pend[1]) raise(1, V_W'($urandom), U_W'($urandom));
            id = pick(pend[0], pend[1]);
            nz = ($urandom_range(0, 3) == 0);
            grant_phase(id, nz);
            rand_words(0, 4);
            mg = (wq.size() > 0) && ($urandom_range(0, 1) == 1);
            engine_job(id, mg, 0);
        end
    endtask

`ifdef WATCHDOG_EN
    task automatic test_watchdog();
        do_reset(2);
        raise(0, V_W'($urandom), U_W'($urandom));
        grant_phase(0, 1'b0);
        rand_words(0, 1);
        engine_job(0, 1'b0, 1);
        raise(1, V_W'($urandom), U_W'($urandom));
        grant_phase(1, 1'b0);
        rand_words(1, 2);
        engine_job(1, 1'b0, 0);
        raise(0, V_W'($urandom), U_W'($urandom));
        grant_phase(0, 1'b0);
        rand_words(0, 1);
        engine_job(0, 1'b0, 2);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_reset_mid_job();
        test_merge();
        test_ignored();
        test_random();
`ifdef WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
